// File: rtl/calc_rs_pkg.sv
// Shared definitions for the calculation reservation station: type codes and widths.
// No logic; constants and enums only.
// Imported by calc_rs, rs_pick and the bench.
package calc_rs_pkg;

  // Width of the instruction-type code carried from the decoder to the ALU
  localparam int INST_TYPE_WIDTH = 6;

  // Default sizing of the station
  localparam int RS_SIZE_DEF = 8;
  localparam int TAG_W_DEF   = 4;
  localparam int DATA_W_DEF  = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Instruction types flagged by the calc classifier
  typedef enum logic [INST_TYPE_WIDTH-1:0] {
    T_NOP   = 6'd0,
    T_LUI   = 6'd1,
    T_AUIPC = 6'd2,
    T_ADD   = 6'd3,
    T_SUB   = 6'd4,
    T_AND   = 6'd5,
    T_OR    = 6'd6,
    T_XOR   = 6'd7,
    T_SLT   = 6'd8,
    T_SLTU  = 6'd9,
    T_SLL   = 6'd10,
    T_SRL   = 6'd11,
    T_SRA   = 6'd12,
    T_ADDI  = 6'd13,
    T_ANDI  = 6'd14,
    T_ORI   = 6'd15,
    T_XORI  = 6'd16,
    T_SLTI  = 6'd17,
    T_SLTIU = 6'd18,
    T_SLLI  = 6'd19,
    T_SRLI  = 6'd20,
    T_SRAI  = 6'd21
  } inst_type_e;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index select: N-bit request vector -> found flag + binary index of lowest set bit.
// Purely combinational, zero latency.
// No handshake; caller decides what to do with the result.
module rs_pick
  import calc_rs_pkg::*;
#(
  parameter int N  = RS_SIZE_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the last hit (lowest index) wins
  always_comb begin
    found_o = FALSE;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = TRUE;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/calc_rs.sv
// Reservation station for calc instructions: buffers issued ops, snoops the CDB, feeds the ALU.
// Entry issued ready at edge t dispatches at edge t+1; a woken entry dispatches one edge after wakeup.
// issue_ready drops when all entries are busy (requests then ignored); ALU never backpressures.
module calc_rs
  import calc_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TYPE_W  = INST_TYPE_WIDTH
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [TYPE_W-1:0] issue_type,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_qj_busy,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic              issue_qk_busy,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [TAG_W-1:0]  issue_dest,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              alu_valid,
  output logic [TYPE_W-1:0] alu_type,
  output logic [TAG_W-1:0]  alu_dest,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_imm,
  output logic [DATA_W-1:0] alu_pc
);

  localparam int IW = $clog2(RS_SIZE);

  // Per-field entry storage
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qjb_q,  qjb_d;
  logic [RS_SIZE-1:0] qkb_q,  qkb_d;
  logic [TYPE_W-1:0]  type_q [RS_SIZE];
  logic [TYPE_W-1:0]  type_d [RS_SIZE];
  logic [DATA_W-1:0]  vj_q   [RS_SIZE];
  logic [DATA_W-1:0]  vj_d   [RS_SIZE];
  logic [DATA_W-1:0]  vk_q   [RS_SIZE];
  logic [DATA_W-1:0]  vk_d   [RS_SIZE];
  logic [TAG_W-1:0]   qj_q   [RS_SIZE];
  logic [TAG_W-1:0]   qj_d   [RS_SIZE];
  logic [TAG_W-1:0]   qk_q   [RS_SIZE];
  logic [TAG_W-1:0]   qk_d   [RS_SIZE];
  logic [DATA_W-1:0]  imm_q  [RS_SIZE];
  logic [DATA_W-1:0]  imm_d  [RS_SIZE];
  logic [DATA_W-1:0]  pc_q   [RS_SIZE];
  logic [DATA_W-1:0]  pc_d   [RS_SIZE];
  logic [TAG_W-1:0]   dest_q [RS_SIZE];
  logic [TAG_W-1:0]   dest_d [RS_SIZE];

  // Dispatch output registers
  logic              alu_valid_q, alu_valid_d;
  logic [TYPE_W-1:0] alu_type_q,  alu_type_d;
  logic [TAG_W-1:0]  alu_dest_q,  alu_dest_d;
  logic [DATA_W-1:0] alu_a_q,     alu_a_d;
  logic [DATA_W-1:0] alu_b_q,     alu_b_d;
  logic [DATA_W-1:0] alu_imm_q,   alu_imm_d;
  logic [DATA_W-1:0] alu_pc_q,    alu_pc_d;

  // Free/ready selection works on registered state only, so an entry freed or
  // written this edge is never reused or dispatched on that same edge.
  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic               fr_found, rd_found;
  logic [IW-1:0]      fr_idx, rd_idx;

  assign free_vec  = ~busy_q;
  assign ready_vec = busy_q & ~qjb_q & ~qkb_q;

  rs_pick #(.N(RS_SIZE), .IW(IW)) u_pick_free (
    .req_i   (free_vec),
    .found_o (fr_found),
    .idx_o   (fr_idx)
  );

  rs_pick #(.N(RS_SIZE), .IW(IW)) u_pick_ready (
    .req_i   (ready_vec),
    .found_o (rd_found),
    .idx_o   (rd_idx)
  );

  assign issue_ready = fr_found;

  assign alu_valid = alu_valid_q;
  assign alu_type  = alu_type_q;
  assign alu_dest  = alu_dest_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_imm   = alu_imm_q;
  assign alu_pc    = alu_pc_q;

  // Next state: flush beats pause beats normal wakeup/dispatch/issue
  always_comb begin
    busy_d = busy_q;
    qjb_d  = qjb_q;
    qkb_d  = qkb_q;
    type_d = type_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    dest_d = dest_q;
    alu_valid_d = FALSE;
    alu_type_d  = alu_type_q;
    alu_dest_d  = alu_dest_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_imm_d   = alu_imm_q;
    alu_pc_d    = alu_pc_q;

    if (clear_in) begin
      busy_d = '0;
    end else if (rdy_in) begin
      // CDB snoop on waiting operands of resident entries
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && qjb_q[i] && cdb_valid && (cdb_tag == qj_q[i])) begin
          vj_d[i]  = cdb_value;
          qjb_d[i] = FALSE;
        end
        if (busy_q[i] && qkb_q[i] && cdb_valid && (cdb_tag == qk_q[i])) begin
          vk_d[i]  = cdb_value;
          qkb_d[i] = FALSE;
        end
      end

      if (rd_found) begin
        alu_valid_d    = TRUE;
        alu_type_d     = type_q[rd_idx];
        alu_dest_d     = dest_q[rd_idx];
        alu_a_d        = vj_q[rd_idx];
        alu_b_d        = vk_q[rd_idx];
        alu_imm_d      = imm_q[rd_idx];
        alu_pc_d       = pc_q[rd_idx];
        busy_d[rd_idx] = FALSE;
      end

      // Issue into a free slot, taking a same-edge CDB value directly
      if (issue_valid && fr_found) begin
        busy_d[fr_idx] = TRUE;
        type_d[fr_idx] = issue_type;
        qj_d[fr_idx]   = issue_qj;
        qk_d[fr_idx]   = issue_qk;
        imm_d[fr_idx]  = issue_imm;
        pc_d[fr_idx]   = issue_pc;
        dest_d[fr_idx] = issue_dest;
        if (issue_qj_busy && cdb_valid && (cdb_tag == issue_qj)) begin
          vj_d[fr_idx]  = cdb_value;
          qjb_d[fr_idx] = FALSE;
        end else begin
          vj_d[fr_idx]  = issue_vj;
          qjb_d[fr_idx] = issue_qj_busy;
        end
        if (issue_qk_busy && cdb_valid && (cdb_tag == issue_qk)) begin
          vk_d[fr_idx]  = cdb_value;
          qkb_d[fr_idx] = FALSE;
        end else begin
          vk_d[fr_idx]  = issue_vk;
          qkb_d[fr_idx] = issue_qk_busy;
        end
      end
    end
  end

  // State registers with async active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      qjb_q  <= '0;
      qkb_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        type_q[i] <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
        dest_q[i] <= '0;
      end
      alu_valid_q <= FALSE;
      alu_type_q  <= '0;
      alu_dest_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_imm_q   <= '0;
      alu_pc_q    <= '0;
    end else begin
      busy_q <= busy_d;
      qjb_q  <= qjb_d;
      qkb_q  <= qkb_d;
      for (int i = 0; i < RS_SIZE; i++) begin
        type_q[i] <= type_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        imm_q[i]  <= imm_d[i];
        pc_q[i]   <= pc_d[i];
        dest_q[i] <= dest_d[i];
      end
      alu_valid_q <= alu_valid_d;
      alu_type_q  <= alu_type_d;
      alu_dest_q  <= alu_dest_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_imm_q   <= alu_imm_d;
      alu_pc_q    <= alu_pc_d;
    end
  end

endmodule
